// File: rtl/max7219_spi_receiver.sv
// MAX7219-compatible SPI receiver: oversamples SCLK/CS/DIN in the clk domain,
// decodes 16-bit frames into the digit rows and control registers.
module max7219_spi_receiver #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sclk_in,
   input  logic       cs_in,
   input  logic       din_in,
   output logic       dout,
   input  logic [2:0] rd_addr,
   output logic [7:0] rd_data,
   output logic [7:0] decode_mode,
   output logic [3:0] intensity,
   output logic [2:0] scan_limit,
   output logic       shutdown_n,
   output logic       display_test,
   output logic       frame_valid,
   output logic [3:0] frame_addr,
   output logic [7:0] frame_data,
   output logic       frame_error
);

   logic [SYNC_STAGES-1:0] sclk_sy, cs_sy, din_sy;
   logic sclk_d, cs_d;
   logic sclk_s, cs_s, din_s;
   logic sclk_rise, sclk_fall, cs_rise, cs_fall;
   logic [15:0] shift;
   logic [4:0]  bit_cnt;
   logic        accept, short_frm;
   logic [3:0]  addr;
   logic [7:0]  data;
   logic [2:0]  row_idx;
   logic [7:0]  rows [8];

   assign sclk_s = sclk_sy[SYNC_STAGES-1];
   assign cs_s   = cs_sy[SYNC_STAGES-1];
   assign din_s  = din_sy[SYNC_STAGES-1];

   assign sclk_rise = sclk_s & ~sclk_d;
   assign sclk_fall = ~sclk_s & sclk_d;
   assign cs_rise   = cs_s & ~cs_d;
   assign cs_fall   = ~cs_s & cs_d;

   // bit_cnt saturates at 16, so bit 4 alone marks a complete frame
   assign accept    = cs_rise & bit_cnt[4];
   assign short_frm = cs_rise & ~bit_cnt[4];
   assign addr      = shift[11:8];
   assign data      = shift[7:0];
   assign row_idx   = addr[2:0] - 3'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sy <= '0;
         cs_sy   <= '1;
         din_sy  <= '0;
         sclk_d  <= 1'b0;
         cs_d    <= 1'b1;
      end else begin
         sclk_sy <= {sclk_sy[SYNC_STAGES-2:0], sclk_in};
         cs_sy   <= {cs_sy[SYNC_STAGES-2:0], cs_in};
         din_sy  <= {din_sy[SYNC_STAGES-2:0], din_in};
         sclk_d  <= sclk_s;
         cs_d    <= cs_s;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift   <= '0;
         bit_cnt <= '0;
         dout    <= 1'b0;
      end else begin
         if (cs_fall) begin
            bit_cnt <= '0;
         end else if (sclk_rise && !cs_s) begin
            shift <= {shift[14:0], din_s};
            if (!bit_cnt[4]) bit_cnt <= bit_cnt + 5'd1;
         end
         if (sclk_fall) dout <= shift[15];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) rows[i] <= '0;
         decode_mode  <= '0;
         intensity    <= '0;
         scan_limit   <= '0;
         shutdown_n   <= 1'b0;
         display_test <= 1'b0;
         frame_valid  <= 1'b0;
         frame_error  <= 1'b0;
         frame_addr   <= '0;
         frame_data   <= '0;
      end else begin
         frame_valid <= accept;
         frame_error <= short_frm;
         if (accept) begin
            frame_addr <= addr;
            frame_data <= data;
            case (addr)
               4'h1, 4'h2, 4'h3, 4'h4,
               4'h5, 4'h6, 4'h7, 4'h8: rows[row_idx] <= data;
               4'h9: decode_mode  <= data;
               4'hA: intensity    <= data[3:0];
               4'hB: scan_limit   <= data[2:0];
               4'hC: shutdown_n   <= data[0];
               4'hF: display_test <= data[0];
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_data <= '0;
      else        rd_data <= rows[rd_addr];
   end

endmodule
